s8254_bus_seq: RTL and testbench

- Host-side bus sequencer for the 8254-compatible timer block (counter 0).
- Turns single-cycle host commands into correctly timed 8254 bus cycles on CS_N, a, id, IOR_N and IOW_N:
  - program mode and initial count;
  - latch and read the current count;
  - read back status plus count.
- Checks count legality before touching the bus and returns read data in one response beat.
- Sits between the host register interface and the timer instance.

---
 rtl/s8254_bus_seq_if.sv | 24 ++
 rtl/s8254_bus_seq.sv | 191 +++++++++++++++++++
 tb/tb_s8254_bus_seq.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/s8254_bus_seq_if.sv
// Host-side command/response port of the 8254 bus sequencer.
// A command is taken in any cycle with cmd_valid && cmd_ready (fields sampled then); rsp_valid is a single-cycle pulse with no backpressure.
interface s8254_bus_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cfg_mode;
  logic        cfg_bcd;
  logic [15:0] cfg_count;
  logic        rsp_valid;
  logic        rsp_err;
  logic [15:0] rsp_count;
  logic [7:0]  rsp_status;

  modport master (
    output cmd_valid, cmd_op, cfg_mode, cfg_bcd, cfg_count,
    input  cmd_ready, rsp_valid, rsp_err, rsp_count, rsp_status
  );

  modport slave (
    input  cmd_valid, cmd_op, cfg_mode, cfg_bcd, cfg_count,
    output cmd_ready, rsp_valid, rsp_err, rsp_count, rsp_status
  );
endinterface

// File: rtl/s8254_bus_seq.sv
// Sequences host commands into 8254 counter-0 bus cycles (program, latch+read, readback).
// Each access is SETUP, STB_CYC strobe cycles, HOLD, then GAP_CYC cycles with CS_N high.
module s8254_bus_seq #(
  parameter int unsigned STB_CYC = 2,
  parameter int unsigned GAP_CYC = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  s8254_bus_seq_if.slave host,
  output logic           CS_N,
  output logic [1:0]     a,
  output logic [7:0]     id,
  input  logic [7:0]     od,
  output logic           IOR_N,
  output logic           IOW_N,
  output logic [2:0]     fsm_state
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    GAP    = 3'd4,
    RESP   = 3'd5
  } state_t;

  localparam logic [3:0] STB_LAST = 4'(STB_CYC - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

  state_t      state, state_n;
  logic [1:0]  idx, idx_n;
  logic [3:0]  cnt, cnt_n;
  logic [1:0]  op;
  logic [2:0]  mode;
  logic        bcd;
  logic [15:0] count;
  logic [7:0]  cap1, cap2, cap3;
  logic        rsp_err_q;
  logic [15:0] rsp_count_q;
  logic [7:0]  rsp_status_q;
  logic        accept, reject, is_read, last_access, on_bus;
  logic [7:0]  wdata;

  function automatic logic cmd_illegal(input logic [1:0] cop, input logic [2:0] cmode,
                                       input logic cbcd, input logic [15:0] ccount);
    logic bad_digit;
    bad_digit = 1'b0;
    for (int i = 0; i < 4; i++)
      if (ccount[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    if (cop == 2'b11) return 1'b1;
    if (cop != 2'b00) return 1'b0;
    return (cmode[2:1] == 2'b11) || (cbcd && bad_digit) ||
           (cmode[1:0] == 2'b11 && ccount == 16'h0001);
  endfunction

  assign accept      = host.cmd_valid && (state == IDLE);
  assign reject      = cmd_illegal(host.cmd_op, host.cfg_mode, host.cfg_bcd, host.cfg_count);
  // Access 0 is always the control-word write; later accesses read for ops 01/10.
  assign is_read     = (idx != 2'd0) && (op != 2'b00);
  assign last_access = (op == 2'b10) ? (idx == 2'd3) : (idx == 2'd2);
  assign on_bus      = state inside {SETUP, STROBE, HOLD};

  always_comb begin
    wdata = 8'h00;
    if (idx == 2'd0) begin
      case (op)
        2'b00:   wdata = {4'b0011, mode, bcd};
        2'b10:   wdata = 8'hC2;
        default: wdata = 8'h00;
      endcase
    end else if (op == 2'b00) begin
      wdata = (idx == 2'd1) ? count[7:0] : count[15:8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= 2'd0;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    case (state)
      IDLE: if (accept) begin
        state_n = reject ? RESP : SETUP;
        idx_n   = 2'd0;
        cnt_n   = 4'd0;
      end
      SETUP: begin
        state_n = STROBE;
        cnt_n   = 4'd0;
      end
      STROBE: if (cnt == STB_LAST) begin
        state_n = HOLD;
        cnt_n   = 4'd0;
      end else begin
        cnt_n = cnt + 4'd1;
      end
      HOLD: begin
        state_n = GAP;
        cnt_n   = 4'd0;
      end
      GAP: if (cnt == GAP_LAST) begin
        cnt_n = 4'd0;
        if (last_access) begin
          state_n = RESP;
        end else begin
          state_n = SETUP;
          idx_n   = idx + 2'd1;
        end
      end else begin
        cnt_n = cnt + 4'd1;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op           <= 2'b00;
      mode         <= 3'b000;
      bcd          <= 1'b0;
      count        <= 16'h0000;
      cap1         <= 8'h00;
      cap2         <= 8'h00;
      cap3         <= 8'h00;
      rsp_err_q    <= 1'b0;
      rsp_count_q  <= 16'h0000;
      rsp_status_q <= 8'h00;
    end else begin
      if (accept) begin
        op    <= host.cmd_op;
        mode  <= host.cfg_mode;
        bcd   <= host.cfg_bcd;
        count <= host.cfg_count;
        if (reject) begin
          rsp_err_q    <= 1'b1;
          rsp_count_q  <= 16'h0000;
          rsp_status_q <= 8'h00;
        end
      end
      // Timer data is taken on the final strobe cycle, just before IOR_N rises.
      if (state == STROBE && is_read && cnt == STB_LAST) begin
        case (idx)
          2'd1:    cap1 <= od;
          2'd2:    cap2 <= od;
          default: cap3 <= od;
        endcase
      end
      if (state == GAP && state_n == RESP) begin
        rsp_err_q <= 1'b0;
        case (op)
          2'b01: begin
            rsp_count_q  <= {cap2, cap1};
            rsp_status_q <= 8'h00;
          end
          2'b10: begin
            rsp_count_q  <= {cap3, cap2};
            rsp_status_q <= cap1;
          end
          default: begin
            rsp_count_q  <= 16'h0000;
            rsp_status_q <= 8'h00;
          end
        endcase
      end
    end
  end

  assign CS_N            = !on_bus;
  assign a               = (on_bus && idx == 2'd0) ? 2'b11 : 2'b00;
  assign id              = (on_bus && !is_read) ? wdata : 8'h00;
  assign IOW_N           = !(state == STROBE && !is_read);
  assign IOR_N           = !(state == STROBE && is_read);
  assign host.cmd_ready  = (state == IDLE);
  assign host.rsp_valid  = (state == RESP);
  assign host.rsp_err    = rsp_err_q;
  assign host.rsp_count  = rsp_count_q;
  assign host.rsp_status = rsp_status_q;
  assign fsm_state       = state;
endmodule

// File: tb/tb_s8254_bus_seq.sv
// Bench for s8254_bus_seq: command driver, 8254 bus monitor/timer model, response scoreboard.
module tb_s8254_bus_seq;
  localparam int STB     = 2;
  localparam int GAP     = 1;
  localparam int ACC_LEN = 1 + STB + 1 + GAP;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  s8254_bus_seq_if h ();
  s8254_bus_seq_if h2 ();

  logic       CS_N, IOR_N, IOW_N;
  logic [1:0] a;
  logic [7:0] id, od;
  logic [2:0] fsm_state;
  logic       CS_N2, IOR_N2, IOW_N2;
  logic [1:0] a2;
  logic [7:0] id2, od2;
  logic [2:0] fsm_state2;
  assign od2 = 8'hA5;

  s8254_bus_seq #(.STB_CYC(STB), .GAP_CYC(GAP)) u_dut (
    .clk(clk), .rst_n(rst_n), .host(h.slave), .CS_N(CS_N), .a(a), .id(id), .od(od),
    .IOR_N(IOR_N), .IOW_N(IOW_N), .fsm_state(fsm_state)
  );

  s8254_bus_seq #(.STB_CYC(1), .GAP_CYC(3)) u_dut_v (
    .clk(clk), .rst_n(rst_n), .host(h2.slave), .CS_N(CS_N2), .a(a2), .id(id2), .od(od2),
    .IOR_N(IOR_N2), .IOW_N(IOW_N2), .fsm_state(fsm_state2)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected response: {err, count[15:0], status[7:0], due_cycle[31:0]}
  logic [56:0] exp_q[$];
  // Expected access: {is_read, a[1:0], id[7:0]}
  logic [10:0] bus_q[$];
  logic [7:0]  od_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic model_err(input logic [1:0] op, input logic [2:0] mode,
                                     input logic bcd, input logic [15:0] cnt);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 4; i++)
      if (((cnt >> (4 * i)) & 16'h000F) > 16'd9) bad = 1'b1;
    if (op == 2'd3) return 1'b1;
    if (op != 2'd0) return 1'b0;
    return (mode >= 3'd6) || (bcd && bad) || ((mode == 3'd3) && cnt == 16'd1);
  endfunction

  task automatic send(input logic [1:0] op, input logic [2:0] mode, input logic bcd,
                      input logic [15:0] cnt, input logic [7:0] r0, input logic [7:0] r1,
                      input logic [7:0] r2, input bit hold, output int acc);
    int          n;
    int          nacc;
    logic        err;
    logic [15:0] rc;
    logic [7:0]  rs;
    n = 0;
    @(negedge clk);
    h.cmd_op    = op;
    h.cfg_mode  = mode;
    h.cfg_bcd   = bcd;
    h.cfg_count = cnt;
    h.cmd_valid = 1'b1;
    while (!h.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!h.cmd_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      h.cmd_valid = 1'b0;
      acc = -1;
      return;
    end
    acc  = cyc;
    err  = model_err(op, mode, bcd, cnt);
    rc   = 16'h0000;
    rs   = 8'h00;
    nacc = 0;
    if (!err) begin
      case (op)
        2'd0: begin
          bus_q.push_back({1'b0, 2'b11, 4'b0011, mode, bcd});
          bus_q.push_back({1'b0, 2'b00, cnt[7:0]});
          bus_q.push_back({1'b0, 2'b00, cnt[15:8]});
          nacc = 3;
        end
        2'd1: begin
          bus_q.push_back({1'b0, 2'b11, 8'h00});
          bus_q.push_back({1'b1, 2'b00, 8'h00});
          bus_q.push_back({1'b1, 2'b00, 8'h00});
          od_q.push_back(r0);
          od_q.push_back(r1);
          rc   = {r1, r0};
          nacc = 3;
        end
        default: begin
          bus_q.push_back({1'b0, 2'b11, 8'hC2});
          for (int k = 0; k < 3; k++) bus_q.push_back({1'b1, 2'b00, 8'h00});
          od_q.push_back(r0);
          od_q.push_back(r1);
          od_q.push_back(r2);
          rs   = r0;
          rc   = {r2, r1};
          nacc = 4;
        end
      endcase
    end
    exp_q.push_back({err, rc, rs, 32'(acc + 1 + nacc * ACC_LEN)});
    if (!hold) begin
      @(negedge clk);
      h.cmd_valid = 1'b0;
      h.cmd_op    = 2'($urandom);
      h.cfg_mode  = 3'($urandom);
      h.cfg_bcd   = 1'($urandom);
      h.cfg_count = 16'($urandom);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !h.cmd_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Response scoreboard
  always @(negedge clk) begin
    logic [56:0] e;
    if (rst_n) begin
      if (exp_q.size() != 0 && 32'(cyc) > exp_q[0][31:0]) begin
        e = exp_q.pop_front();
        check("rsp_timeout", 32'(cyc), e[31:0]);
      end
      if (h.rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_cycle", 32'(cyc), e[31:0]);
          check("rsp_err", 32'(h.rsp_err), 32'(e[56]));
          check("rsp_count", 32'(h.rsp_count), 32'(e[55:40]));
          check("rsp_status", 32'(h.rsp_status), 32'(e[39:32]));
        end
      end
    end
  end

  // Bus monitor and timer data model
  bit          in_acc, rd_seen, setup_ok, hold_ok, stable_ok;
  int          cs_len, stb_len;
  logic [1:0]  a0;
  logic [7:0]  id0;
  logic [10:0] be;
  always @(negedge clk) begin
    if (!rst_n) begin
      in_acc = 1'b0;
      bus_q.delete();
      od_q.delete();
      od = 8'h00;
    end else begin
      od = 8'($urandom);
      check("bus_safety", 32'((!IOR_N && !IOW_N) || ((!IOR_N || !IOW_N) && CS_N)), 32'd0);
      if (!CS_N) begin
        if (!in_acc) begin
          in_acc    = 1'b1;
          cs_len    = 0;
          stb_len   = 0;
          a0        = a;
          id0       = id;
          rd_seen   = 1'b0;
          stable_ok = 1'b1;
          setup_ok  = IOR_N && IOW_N;
        end else if (a !== a0 || id !== id0) begin
          stable_ok = 1'b0;
        end
        cs_len++;
        if (!IOR_N) begin
          rd_seen = 1'b1;
          stb_len++;
          if (stb_len == STB && od_q.size() != 0) od = od_q.pop_front();
        end
        if (!IOW_N) stb_len++;
        hold_ok = IOR_N && IOW_N;
      end else begin
        check("idle_bus", 32'({a, id}), 32'd0);
        if (in_acc) begin
          in_acc = 1'b0;
          if (bus_q.size() == 0) begin
            check("unexpected_access", 32'd1, 32'd0);
          end else begin
            be = bus_q.pop_front();
            check("access", 32'({rd_seen, a0, id0}), 32'(be));
            check("access_shape",
                  32'(cs_len * 256 + stb_len * 8 + int'(setup_ok) * 4 + int'(hold_ok) * 2 + int'(stable_ok)),
                  32'((STB + 2) * 256 + STB * 8 + 7));
          end
        end
      end
    end
  end

  initial begin
    int          acc, acc1, acc2, v_acc, v_n, cs_low, fall1, fall2;
    logic        prev_cs;
    logic [1:0]  rop;
    logic [15:0] rcnt;
    bit          hold;
    h.cmd_valid  = 1'b0;
    h.cmd_op     = 2'b00;
    h.cfg_mode   = 3'b000;
    h.cfg_bcd    = 1'b0;
    h.cfg_count  = 16'h0000;
    h2.cmd_valid = 1'b0;
    h2.cmd_op    = 2'b00;
    h2.cfg_mode  = 3'b000;
    h2.cfg_bcd   = 1'b0;
    h2.cfg_count = 16'h0000;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_bus", 32'({CS_N, IOR_N, IOW_N, a, id}), 32'({3'b111, 2'b00, 8'h00}));
    check("rst_ready", 32'(h.cmd_ready), 32'd1);
    check("rst_rsp", 32'({h.rsp_valid, h.rsp_err, h.rsp_count, h.rsp_status}), 32'd0);
    rst_n = 1'b1;

    // Directed cases
    send(2'd0, 3'b010, 1'b0, 16'h1234, 8'h00, 8'h00, 8'h00, 1'b0, acc);
    wait_idle();
    send(2'd0, 3'b000, 1'b1, 16'h1A99, 8'h00, 8'h00, 8'h00, 1'b0, acc);
    wait_idle();
    send(2'd0, 3'b011, 1'b0, 16'h0001, 8'h00, 8'h00, 8'h00, 1'b0, acc);
    wait_idle();
    send(2'd0, 3'b011, 1'b0, 16'h0002, 8'h00, 8'h00, 8'h00, 1'b0, acc);
    wait_idle();
    send(2'd3, 3'b000, 1'b0, 16'h0000, 8'h00, 8'h00, 8'h00, 1'b0, acc);
    wait_idle();
    send(2'd2, 3'b000, 1'b0, 16'h0000, 8'h96, 8'h78, 8'h56, 1'b0, acc);
    wait_idle();

    // Reset during the strobe of the second program write
    send(2'd0, 3'b010, 1'b0, 16'h1234, 8'h00, 8'h00, 8'h00, 1'b0, acc);
    while (cyc < acc + 1 + ACC_LEN + 1) @(negedge clk);
    check("abort_in_strobe", 32'(IOW_N), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_bus", 32'({CS_N, IOR_N, IOW_N}), 32'({3'b111}));
    check("abort_ready", 32'(h.cmd_ready), 32'd1);
    check("abort_no_rsp", 32'(h.rsp_valid), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);

    // cmd_valid held across two latch+read commands
    send(2'd1, 3'b000, 1'b0, 16'h0000, 8'h3C, 8'hA1, 8'h00, 1'b1, acc1);
    send(2'd1, 3'b101, 1'b1, 16'hFFFF, 8'h0F, 8'hE7, 8'h00, 1'b0, acc2);
    check("b2b_accept", 32'(acc2), 32'(acc1 + 1 + 3 * ACC_LEN + 1));
    wait_idle();

    // Randomized commands
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       rcnt = 16'h0001;
        1:       rcnt = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                         4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        default: rcnt = 16'($urandom);
      endcase
      hold = (i < 39) && ($urandom_range(0, 2) == 0);
      send(rop, 3'($urandom), ($urandom_range(0, 3) == 0), rcnt,
           8'($urandom), 8'($urandom), 8'($urandom), hold, acc);
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    check("bus_q_empty", 32'(bus_q.size()), 32'd0);

    // Short-strobe / long-gap instance: latch+read with constant timer data
    @(negedge clk);
    h2.cmd_op    = 2'b01;
    h2.cmd_valid = 1'b1;
    v_n = 0;
    while (!h2.cmd_ready && v_n < 50) begin
      @(negedge clk);
      v_n++;
    end
    v_acc = cyc;
    @(negedge clk);
    h2.cmd_valid = 1'b0;
    cs_low  = 0;
    fall1   = -1;
    fall2   = -1;
    prev_cs = 1'b1;
    v_n     = 0;
    while (!h2.rsp_valid && v_n < 60) begin
      check("v_safety", 32'((!IOR_N2 && !IOW_N2) || ((!IOR_N2 || !IOW_N2) && CS_N2)), 32'd0);
      if (!CS_N2) begin
        cs_low++;
        if (prev_cs) begin
          if (fall1 < 0) fall1 = cyc;
          else if (fall2 < 0) fall2 = cyc;
        end
      end
      prev_cs = CS_N2;
      @(negedge clk);
      v_n++;
    end
    check("v_rsp_valid", 32'(h2.rsp_valid), 32'd1);
    check("v_latency", 32'(cyc - v_acc), 32'd19);
    check("v_access_len", 32'(fall2 - fall1), 32'd6);
    check("v_cs_low_total", 32'(cs_low), 32'd9);
    check("v_rsp", 32'({h2.rsp_err, h2.rsp_count}), 32'({1'b0, 16'hA5A5}));

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
